// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq
//   Iterative RV32M multiply/divide sequencer that sits beside the execute
//   stage. It accepts one operation, iterates one bit per cycle on operand
//   magnitudes (shift-add multiply, restoring divide), applies the sign
//   fix-up and registers a single result word. It holds the pipeline until
//   the result is ready.
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   start_i   EX holds a valid M-extension op (level, held while stalled)
//   annul_i   flush of the EX instruction; aborts any operation
//   op_i      funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   opa_i     rs1 value, sampled at accept
//   opb_i     rs2 value, sampled at accept
//   stall_o   pipeline hold request (combinational)
//   busy_o    sequencer not idle
//   ready_o   one-cycle pulse, result_o valid for the held instruction
//   result_o  result word, held until the next accept
module ex_muldiv_seq #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            annul_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] opa_i,
   input  logic [XLEN-1:0] opb_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            ready_o,
   output logic [XLEN-1:0] result_o
);

   localparam int unsigned CW = $clog2(XLEN);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state_q,  state_d;
   logic [2:0]        op_q,     op_d;
   logic              neg_a_q,  neg_a_d;
   logic              neg_b_q,  neg_b_d;
   logic [XLEN-1:0]   b_q,      b_d;
   logic [2*XLEN-1:0] acc_q,    acc_d;
   logic [CW-1:0]     cnt_q,    cnt_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              accept;
   logic              sign_a, sign_b;
   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_step;
   logic [XLEN:0]     rem_sh, div_diff;
   logic [2*XLEN-1:0] div_step;
   logic [2*XLEN-1:0] acc_step;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix;
   logic [XLEN-1:0]   fin_result;

   always_comb begin
      accept = (state_q == S_IDLE) && start_i && !annul_i;

      // Signedness of each operand as decoded from funct3
      sign_a = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
      sign_b = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
      a_neg  = sign_a && opa_i[XLEN-1];
      b_neg  = sign_b && opb_i[XLEN-1];
      a_mag  = a_neg ? -opa_i : opa_i;
      b_mag  = b_neg ? -opb_i : opb_i;

      // Multiply: acc = {partial high, remaining multiplier bits}
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      mul_step = {mul_sum, acc_q[XLEN-1:1]};

      // Divide: acc = {partial remainder, dividend/quotient bits}.
      // A negative trial result implies rem_sh < divisor, so its top bit is 0.
      rem_sh   = acc_q[2*XLEN-1:XLEN-1];
      div_diff = rem_sh - {1'b0, b_q};
      div_step = div_diff[XLEN] ? {rem_sh[XLEN-1:0],   acc_q[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

      acc_step = op_q[2] ? div_step : mul_step;

      // Sign fix-up on the value the final iteration produces
      prod_fix = (neg_a_q ^ neg_b_q) ? -acc_step : acc_step;
      quot_fix = (neg_a_q ^ neg_b_q) ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
      rem_fix  = neg_a_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

      case (op_q)
         3'd0:          fin_result = prod_fix[XLEN-1:0];
         3'd1, 3'd2,
         3'd3:          fin_result = prod_fix[2*XLEN-1:XLEN];
         3'd4, 3'd5:    fin_result = quot_fix;
         default:       fin_result = rem_fix;
      endcase

      state_d  = state_q;
      op_d     = op_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d    = op_i;
               neg_a_d = a_neg;
               neg_b_d = b_neg;
               b_d     = b_mag;
               acc_d   = {{XLEN{1'b0}}, a_mag};
               cnt_d   = '0;
               state_d = S_CALC;
               if (op_i[2]) begin
                  if (opb_i == '0) begin
                     state_d  = S_DONE;
                     result_d = op_i[1] ? opa_i : '1;
                  end else if (sign_b && (opa_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                               (opb_i == '1)) begin
                     state_d  = S_DONE;
                     result_d = op_i[1] ? '0 : opa_i;
                  end
               end
            end
         end
         S_CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN-1)) begin
               state_d  = S_DONE;
               result_d = fin_result;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A flush abandons the operation and leaves the previous result intact
      if (annul_i) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign stall_o  = accept || (state_q == S_CALC);
   assign busy_o   = (state_q != S_IDLE);
   assign ready_o  = (state_q == S_DONE) && !annul_i;
   assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
module tb_ex_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        annul_i;
   logic [2:0]  op_i;
   logic [31:0] opa_i;
   logic [31:0] opb_i;
   logic        stall_o;
   logic        busy_o;
   logic        ready_o;
   logic [31:0] result_o;

   int unsigned passed = 0;
   int unsigned failed = 0;
   int unsigned total  = 0;
   logic [31:0] last_res;

   ex_muldiv_seq #(.XLEN(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .annul_i  (annul_i),
      .op_i     (op_i),
      .opa_i    (opa_i),
      .opb_i    (opb_i),
      .stall_o  (stall_o),
      .busy_o   (busy_o),
      .ready_o  (ready_o),
      .result_o (result_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference RV32M semantics using plain 64-bit arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic [63:0] ua, ub, p;
      logic [31:0] r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (f)
         3'd0: begin p = ua * ub; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * $signed(ub); r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else begin p = sa / sb; r = p[31:0]; end
         end
         3'd5: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else begin p = ua / ub; r = p[31:0]; end
         end
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
            else begin p = sa % sb; r = p[31:0]; end
         end
         default: begin
            if (b == 0) r = a;
            else begin p = ua % ub; r = p[31:0]; end
         end
      endcase
      return r;
   endfunction

   function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
      if (f >= 3'd4 && b == 0) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b);
      logic [31:0] exp;
      int lat;
      int n;
      bit seen;
      exp = ref_model(f, a, b);
      lat = exp_latency(f, a, b);
      @(negedge clk);
      op_i = f; opa_i = a; opb_i = b; start_i = 1'b1;
      #1 check({tag, " stall@accept"}, stall_o, 1);
      @(posedge clk);
      n = 1;
      seen = 0;
      while (n <= 40) begin
         #1;
         if (ready_o) begin
            seen = 1;
            break;
         end
         check({tag, " stall@calc"}, stall_o, 1);
         @(posedge clk);
         n++;
      end
      start_i = 1'b0;
      check({tag, " ready seen"}, seen, 1);
      check({tag, " latency"}, n, lat);
      check({tag, " stall@ready"}, stall_o, 0);
      check({tag, " result"}, result_o, exp);
      @(posedge clk);
      #1;
      check({tag, " ready pulse width"}, ready_o, 0);
      check({tag, " result held"}, result_o, exp);
      last_res = exp;
   endtask

   initial begin
      int pulses;
      logic [2:0]  rf;
      logic [31:0] ra, rb;

      rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
      op_i = '0; opa_i = '0; opb_i = '0;
      last_res = '0;
      #1;
      check("reset stall", stall_o, 0);
      check("reset busy", busy_o, 0);
      check("reset ready", ready_o, 0);
      check("reset result", result_o, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Directed cases
      run_op("MUL 7*6", 3'd0, 32'd7, 32'd6);
      check("MUL 7*6 value", last_res, 32'h0000_002A);
      run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2);
      check("DIV -7/2 value", last_res, 32'hFFFF_FFFD);
      run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2);
      check("REM -7/2 value", last_res, 32'hFFFF_FFFF);
      run_op("DIVU max/2", 3'd5, 32'hFFFF_FFFF, 32'd2);
      check("DIVU max/2 value", last_res, 32'h7FFF_FFFF);
      run_op("DIV 5/0", 3'd4, 32'd5, 32'd0);
      check("DIV 5/0 value", last_res, 32'hFFFF_FFFF);
      run_op("REM 5/0", 3'd6, 32'd5, 32'd0);
      check("REM 5/0 value", last_res, 32'd5);
      run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      check("DIV ovf value", last_res, 32'h8000_0000);
      run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      check("REM ovf value", last_res, 32'd0);
      run_op("MULH min^2", 3'd1, 32'h8000_0000, 32'h8000_0000);
      check("MULH min^2 value", last_res, 32'h4000_0000);
      run_op("MULHU max^2", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("MULHU max^2 value", last_res, 32'hFFFF_FFFE);
      run_op("MULHSU -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2);
      check("MULHSU -1*2 value", last_res, 32'hFFFF_FFFF);

      // start_i held through DONE is only taken in the following IDLE
      @(negedge clk);
      op_i = 3'd4; opa_i = 32'd5; opb_i = 32'd0; start_i = 1'b1;
      @(posedge clk);
      #1 check("hold DONE ready", ready_o, 1);
      op_i = 3'd6;
      @(posedge clk);
      #1;
      check("hold IDLE busy", busy_o, 0);
      check("hold IDLE ready", ready_o, 0);
      check("hold IDLE stall", stall_o, 1);
      @(posedge clk);
      #1;
      start_i = 1'b0;
      check("hold reaccept ready", ready_o, 1);
      check("hold reaccept result", result_o, 32'd5);
      last_res = 32'd5;

      // Annul at T+10
      @(negedge clk);
      op_i = 3'd0; opa_i = 32'd11; opb_i = 32'd13; start_i = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      #1;
      check("annul pre stall", stall_o, 1);
      annul_i = 1'b1;
      start_i = 1'b0;
      #1 check("annul cycle ready", ready_o, 0);
      @(posedge clk);
      #1;
      annul_i = 1'b0;
      #1;
      check("annul busy", busy_o, 0);
      check("annul stall", stall_o, 0);
      check("annul result kept", result_o, last_res);
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1 if (ready_o) pulses++;
      end
      check("annul no ready", pulses, 0);
      run_op("MUL 3*3 after annul", 3'd0, 32'd3, 32'd3);
      check("MUL 3*3 value", last_res, 32'd9);

      // Asynchronous reset at T+5
      @(negedge clk);
      op_i = 3'd5; opa_i = 32'd1000; opb_i = 32'd3; start_i = 1'b1;
      @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
      start_i = 1'b0;
      rst = 1'b0;
      #1;
      check("rst stall", stall_o, 0);
      check("rst busy", busy_o, 0);
      check("rst ready", ready_o, 0);
      check("rst result", result_o, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 check("post rst busy", busy_o, 0);
      run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7);
      check("DIVU 100/7 value", last_res, 32'd14);

      // Randomized operations with corner operand values mixed in
      for (int i = 0; i < 40; i++) begin
         rf = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0: ra = 32'd0;
            1: ra = 32'hFFFF_FFFF;
            2: ra = 32'h8000_0000;
            3: ra = 32'($urandom_range(0, 255));
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'h8000_0000;
            3: rb = 32'($urandom_range(1, 255));
            default: rb = $urandom;
         endcase
         run_op($sformatf("rand%0d op%0d", i, rf), rf, ra, rb);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
